// File: rtl/counting_element.sv
// counting_element: 8254 channel down-counter with mode 0/2/3 output and latchable readback
module counting_element (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] initial_count,
  input  logic       load,
  input  logic [2:0] mode,
  input  logic       gate,
  input  logic       latch,
  input  logic       read,
  output logic       out,
  output logic [7:0] read_data,
  output logic       null_count
);
  typedef enum logic [1:0] {IDLE, XFER, COUNT} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cr_q, cr_d;
  logic [1:0]  mode_q, mode_d;
  logic [8:0]  ce_q, ce_d;
  logic [7:0]  half_q, half_d;
  logic        out_q, out_d;
  logic        nc_q, nc_d;
  logic [7:0]  ol_q, ol_d;
  logic        latched_q, latched_d;
  logic [7:0]  rd_q, rd_d;
  logic        gate_q;
  logic [1:0]  new_mode;
  logic [8:0]  dec;
  logic [7:0]  low_at;
  logic        reload;
  logic        keep;
  // Counting-element value for a count: 0 means 256, and 1 is stretched to 2 in the periodic modes
  function automatic logic [8:0] eff(input logic [7:0] v, input logic [1:0] m);
    return v == 8'd0 ? 9'd256 : (v == 8'd1 && m != 2'd0) ? 9'd2 : {1'b0, v};
  endfunction
  // Value of ce at which the square wave enters its low phase (floor of the effective count / 2)
  function automatic logic [7:0] half(input logic [7:0] v);
    return v == 8'd0 ? 8'd128 : v == 8'd1 ? 8'd1 : {1'b0, v[7:1]};
  endfunction
  assign new_mode = (mode == 3'd2 || mode == 3'd6) ? 2'd2 : (mode == 3'd3 || mode == 3'd7) ? 2'd3 : 2'd0;
  assign dec      = ce_q - 9'd1;
  assign low_at   = mode_q == 2'd3 ? half_q : 8'd1;
  assign reload   = state_q == COUNT && mode_q != 2'd0 && gate && (!gate_q || ce_q == 9'd1);
  assign keep     = load && state_q == COUNT && mode_q != 2'd0 && new_mode != 2'd0;
  // Next-state, counting, output waveform and readback latch
  always_comb begin
    state_d   = state_q;
    cr_d      = cr_q;
    mode_d    = mode_q;
    ce_d      = ce_q;
    half_d    = half_q;
    out_d     = out_q;
    nc_d      = nc_q;
    ol_d      = ol_q;
    latched_d = latched_q;
    case (state_q)
      IDLE: out_d = 1'b1;
      XFER: begin
        ce_d    = eff(cr_q, mode_q);
        half_d  = half(cr_q);
        nc_d    = 1'b0;
        state_d = COUNT;
        out_d   = mode_q == 2'd0 ? out_q : 1'b1;
      end
      COUNT: begin
        if (mode_q == 2'd0) begin
          ce_d  = gate ? {1'b0, dec[7:0]} : ce_q;
          out_d = out_q | (gate && ce_q == 9'd1);
        end else if (!gate) begin
          out_d = 1'b1;
        end else if (reload) begin
          ce_d   = eff(cr_q, mode_q);
          half_d = half(cr_q);
          out_d  = 1'b1;
          nc_d   = 1'b0;
        end else begin
          ce_d  = dec;
          out_d = dec == {1'b0, low_at} ? 1'b0 : out_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      cr_d   = initial_count;
      mode_d = new_mode;
      if (keep && reload) begin
        ce_d   = eff(initial_count, new_mode);
        half_d = half(initial_count);
      end else begin
        nc_d = 1'b1;
      end
      if (!keep) begin
        state_d = XFER;
        out_d   = new_mode == 2'd0 ? 1'b0 : out_d;
      end
    end
    if (latch && !latched_q) begin
      ol_d      = ce_q[7:0];
      latched_d = 1'b1;
    end
    if (read) latched_d = 1'b0;
    rd_d = latched_d ? ol_d : ce_d[7:0];
  end
  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cr_q      <= 8'd0;
      mode_q    <= 2'd0;
      ce_q      <= 9'd0;
      half_q    <= 8'd0;
      out_q     <= 1'b1;
      nc_q      <= 1'b0;
      ol_q      <= 8'd0;
      latched_q <= 1'b0;
      rd_q      <= 8'd0;
      gate_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cr_q      <= cr_d;
      mode_q    <= mode_d;
      ce_q      <= ce_d;
      half_q    <= half_d;
      out_q     <= out_d;
      nc_q      <= nc_d;
      ol_q      <= ol_d;
      latched_q <= latched_d;
      rd_q      <= rd_d;
      gate_q    <= gate;
    end
  end
  assign out        = out_q;
  assign read_data  = rd_q;
  assign null_count = nc_q;
endmodule

// File: tb/tb_counting_element.sv
// tb_counting_element: directed self-checking bench for counting_element
module tb_counting_element;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] initial_count = 8'd0;
  logic       load = 1'b0;
  logic [2:0] mode = 3'd0;
  logic       gate = 1'b1;
  logic       latch = 1'b0;
  logic       read = 1'b0;
  logic       out;
  logic [7:0] read_data;
  logic       null_count;
  int         n_tests = 0;
  int         n_fail = 0;
  int         hi, lo;
  logic [7:0] exp_ce2 [8] = '{8'd3, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1, 8'd4};
  logic       exp_o2 [8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic       exp_o3 [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  counting_element dut (
    .clk(clk), .reset(reset), .initial_count(initial_count), .load(load), .mode(mode),
    .gate(gate), .latch(latch), .read(read), .out(out), .read_data(read_data),
    .null_count(null_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic reset_dut();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask
  task automatic do_load(input logic [2:0] m, input logic [7:0] n);
    mode = m;
    initial_count = n;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    #12;
    check("rst_out", out, 1);
    check("rst_rd", read_data, 0);
    check("rst_nc", null_count, 0);
    reset = 1'b0;
    tick();
    do_load(3'd0, 8'd5);
    check("m0_out_L", out, 0);
    check("m0_nc_L", null_count, 1);
    tick();
    check("m0_ce_L1", read_data, 5);
    check("m0_nc_L1", null_count, 0);
    tick(4);
    check("m0_ce_L5", read_data, 1);
    check("m0_out_L5", out, 0);
    tick();
    check("m0_ce_L6", read_data, 0);
    check("m0_out_L6", out, 1);
    tick();
    check("m0_wrap", read_data, 255);
    check("m0_out_L7", out, 1);
    do_load(3'd4, 8'd10);
    tick(4);
    check("lat_pre", read_data, 7);
    latch = 1'b1;
    tick();
    latch = 1'b0;
    check("lat_hold", read_data, 7);
    tick(2);
    check("lat_hold2", read_data, 7);
    latch = 1'b1;
    tick();
    latch = 1'b0;
    check("lat_ignored", read_data, 7);
    read = 1'b1;
    tick();
    read = 1'b0;
    check("lat_read", read_data, 2);
    check("lat_out", out, 0);
    tick();
    check("lat_live", read_data, 1);
    latch = 1'b1;
    read = 1'b1;
    tick();
    latch = 1'b0;
    read = 1'b0;
    check("lat_rd_win", read_data, 0);
    check("lat_out_tc", out, 1);
    tick();
    check("lat_rd_win2", read_data, 255);
    reset_dut();
    do_load(3'd2, 8'd4);
    tick();
    check("m2_ce1", read_data, 4);
    check("m2_out1", out, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("m2_ce_%0d", i), read_data, exp_ce2[i]);
      check($sformatf("m2_out_%0d", i), out, exp_o2[i]);
    end
    tick(3);
    check("m2_low_ce", read_data, 1);
    check("m2_low_out", out, 0);
    gate = 1'b0;
    tick();
    check("m2_g0_out", out, 1);
    check("m2_g0_ce", read_data, 1);
    tick(2);
    check("m2_g0_out3", out, 1);
    check("m2_g0_ce3", read_data, 1);
    gate = 1'b1;
    tick();
    check("m2_grise_ce", read_data, 4);
    check("m2_grise_out", out, 1);
    tick();
    check("m2_grise_dec", read_data, 3);
    reset_dut();
    do_load(3'd3, 8'd5);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("m3_out_%0d", i), out, exp_o3[i]);
    end
    reset_dut();
    do_load(3'd7, 8'd0);
    tick();
    check("m3z_ce", read_data, 0);
    hi = 0;
    while (out === 1'b1 && hi < 300) begin
      hi++;
      tick();
    end
    lo = 0;
    while (out === 1'b0 && lo < 300) begin
      lo++;
      tick();
    end
    check("m3z_hi", hi, 128);
    check("m3z_lo", lo, 128);
    reset_dut();
    do_load(3'd6, 8'd6);
    tick(3);
    do_load(3'd2, 8'd3);
    check("rl_nc_set", null_count, 1);
    check("rl_ce_e4", read_data, 3);
    tick(2);
    check("rl_ce_e6", read_data, 1);
    check("rl_out_e6", out, 0);
    check("rl_nc_e6", null_count, 1);
    tick();
    check("rl_ce_e7", read_data, 3);
    check("rl_out_e7", out, 1);
    check("rl_nc_e7", null_count, 0);
    tick(2);
    check("rl_out_e9", out, 0);
    tick();
    check("rl_ce_e10", read_data, 3);
    tick(2);
    do_load(3'd2, 8'd5);
    check("rl_same_ce", read_data, 5);
    check("rl_same_nc", null_count, 0);
    check("rl_same_out", out, 1);
    tick(4);
    check("rst_mid_ce", read_data, 1);
    check("rst_mid_out", out, 0);
    reset = 1'b1;
    #2;
    check("async_out", out, 1);
    check("async_rd", read_data, 0);
    check("async_nc", null_count, 0);
    reset = 1'b0;
    tick(3);
    check("idle_out", out, 1);
    check("idle_rd", read_data, 0);
    check("idle_nc", null_count, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
